// File: rtl/ser_par_pkg.sv
// rtl/ser_par_pkg.sv - shared types, defaults and fixed-point helper for ser_par_bank
package ser_par_pkg;

   localparam int DEF_WIDTH = 12;
   localparam int DEF_FRAC  = 10;
   localparam int DEF_N_REG = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   // Real value to default-width signed fixed point, rounded to nearest LSB.
   function automatic logic [DEF_WIDTH-1:0] to_q(input real r);
      return DEF_WIDTH'(int'(r * real'(1 << DEF_FRAC)));
   endfunction

endpackage

// File: rtl/ser_shift.sv
// rtl/ser_shift.sv - MSB-first serial-in shift register with clear and enable
module ser_shift #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   // Left shift, new bit enters at LSB; clear has priority over shifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= (q << 1) | W'(din);
      end
   end

endmodule

// File: rtl/ser_par_bank.sv
// rtl/ser_par_bank.sv - framed serial loader into a shadow bank with atomic commit
module ser_par_bank
   import ser_par_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int FRAC   = DEF_FRAC,
   parameter int N_REG  = DEF_N_REG,
   parameter int ADDR_W = $clog2(N_REG)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               enable,
   input  logic                               din,
   input  logic                               commit,
   output logic signed [N_REG-1:0][WIDTH-1:0] soglia,
   output logic                               busy,
   output logic                               wr_done,
   output logic [ADDR_W-1:0]                  wr_addr,
   output logic                               frame_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   if (N_REG < 2 || FRAC > WIDTH || ADDR_W != $clog2(N_REG)) begin : g_param_check
      $error("ser_par_bank: illegal parameter set");
   end

   state_t                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           shift_a, shift_d, clr;
   logic                           wr_en, err;
   logic                           addr_ok;
   logic [ADDR_W-1:0]              addr_q;
   logic [WIDTH-1:0]               data_q;
   logic [WIDTH-1:0]               word;
   logic [N_REG-1:0][WIDTH-1:0]    shadow_q, shadow_d;

   ser_shift #(.W(ADDR_W)) u_addr_shift (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (shift_a),
      .din (din),
      .q   (addr_q)
   );

   ser_shift #(.W(WIDTH)) u_data_shift (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (shift_d),
      .din (din),
      .q   (data_q)
   );

   // The word is complete on the edge that samples its last bit, so it is
   // assembled from the shift register plus the bit currently on din.
   assign word    = {data_q[WIDTH-2:0], din};
   assign addr_ok = 32'(addr_q) < N_REG;

   // FSM state and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: start always wins and restarts the frame, aborting any frame in flight.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_a = 1'b0;
      shift_d = 1'b0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      err     = 1'b0;
      if (start) begin
         clr     = 1'b1;
         state_d = ADDR;
         cnt_d   = '0;
         err     = (state_q != IDLE);
      end else if (enable) begin
         case (state_q)
            ADDR: begin
               shift_a = 1'b1;
               if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               shift_d = 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  wr_en   = addr_ok;
                  err     = !addr_ok;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shadow bank with the pending write folded in, so a coincident commit sees it.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) begin
         shadow_d[addr_q] = word;
      end
   end

   // Registered status pulses, shadow bank and the committed threshold set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= 1'b0;
         wr_done   <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
         shadow_q  <= '0;
         soglia    <= '0;
      end else begin
         busy      <= (state_d != IDLE);
         wr_done   <= wr_en;
         frame_err <= err;
         if (wr_en) begin
            wr_addr <= addr_q;
         end
         shadow_q <= shadow_d;
         if (commit) begin
            soglia <= shadow_d;
         end
      end
   end

endmodule

// File: tb/tb_ser_par_bank.sv
// tb/tb_ser_par_bank.sv - self-checking bench for ser_par_bank (N_REG=4 and N_REG=3 builds)
module tb_ser_par_bank;
   import ser_par_pkg::to_q;

   localparam int W  = 12;
   localparam int N  = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, enable = 1'b0, din = 1'b0, commit = 1'b0;

   logic signed [N-1:0][W-1:0]  soglia;
   logic                        busy, wr_done, frame_err;
   logic [1:0]                  wr_addr;
   logic signed [N3-1:0][W-1:0] soglia3;
   logic                        busy3, wr_done3, frame_err3;
   logic [1:0]                  wr_addr3;

   ser_par_bank #(.WIDTH(W), .FRAC(10), .N_REG(N)) dut (
      .clk(clk), .rst(rst), .start(start), .enable(enable), .din(din), .commit(commit),
      .soglia(soglia), .busy(busy), .wr_done(wr_done), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   ser_par_bank #(.WIDTH(W), .FRAC(10), .N_REG(N3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .enable(enable), .din(din), .commit(commit),
      .soglia(soglia3), .busy(busy3), .wr_done(wr_done3), .wr_addr(wr_addr3), .frame_err(frame_err3)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: shadow and committed sets for both builds.
   logic [W-1:0] sh_m[N], act_m[N], sh3_m[N3], act3_m[N3];

   typedef struct {
      logic       done, err, done3, err3, busy;
      logic [1:0] waddr, waddr3;
      int         busy_cycles;
   } obs_t;

   typedef struct {
      int         addr;
      logic [W-1:0] word;
      bit         toggle;
      bit         commit_last;
      logic       exp_done, exp_err, exp_done3, exp_err3;
      logic [1:0] exp_waddr, exp_waddr3;
      int         exp_busy;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_commit();
      for (int i = 0; i < N; i++)  act_m[i]  = sh_m[i];
      for (int i = 0; i < N3; i++) act3_m[i] = sh3_m[i];
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++)  begin sh_m[i]  = '0; act_m[i]  = '0; end
      for (int i = 0; i < N3; i++) begin sh3_m[i] = '0; act3_m[i] = '0; end
   endtask

   function automatic logic [63:0] vec_m();
      logic [63:0] v = '0;
      for (int i = 0; i < N; i++) v[i*W +: W] = act_m[i];
      return v;
   endfunction

   function automatic logic [63:0] vec3_m();
      logic [63:0] v = '0;
      for (int i = 0; i < N3; i++) v[i*W +: W] = act3_m[i];
      return v;
   endfunction

   task automatic check_soglia(input string tag);
      check({tag, "_soglia"},  64'($unsigned(soglia)),  vec_m());
      check({tag, "_soglia3"}, 64'($unsigned(soglia3)), vec3_m());
   endtask

   // One clock: inputs applied before the edge, outputs observed 1 ns after it.
   task automatic cyc(input logic s, input logic e, input logic d, input logic c);
      start = s; enable = e; din = d; commit = c;
      @(posedge clk);
      #1;
      start = 1'b0; enable = 1'b0; din = 1'b0; commit = 1'b0;
      if (c) model_commit();
   endtask

   // Sends {addr[1:0], word} MSB first. abort_at >= 0 replaces that bit with a start.
   task automatic frame(input int a, input logic [W-1:0] w, input int gap_max, input bit toggle,
                        input bit commit_last, input bit with_start, input int abort_at,
                        output obs_t o);
      logic [13:0] bits;
      bits = {2'(a), w};
      o.busy_cycles = 0;
      if (with_start) begin
         cyc(1'b1, 1'b0, 1'($urandom), 1'b0);
         if (busy) o.busy_cycles++;
      end
      for (int i = 0; i < 14; i++) begin
         if (i == abort_at) begin
            cyc(1'b1, 1'b1, bits[13-i], 1'b0);
            o.done = wr_done; o.err = frame_err; o.busy = busy;
            o.done3 = wr_done3; o.err3 = frame_err3;
            o.waddr = wr_addr; o.waddr3 = wr_addr3;
            return;
         end
         if (i == 13) begin
            if (a < N)  sh_m[a]  = w;
            if (a < N3) sh3_m[a] = w;
            cyc(1'b0, 1'b1, bits[13-i], commit_last);
         end else begin
            cyc(1'b0, 1'b1, bits[13-i], 1'b0);
         end
         if (busy) o.busy_cycles++;
         if (i < 13) begin
            int g;
            g = toggle ? 1 : int'($urandom_range(gap_max, 0));
            for (int k = 0; k < g; k++) begin
               logic c;
               c = (gap_max > 0) && ($urandom % 5 == 0);
               cyc(1'b0, 1'b0, 1'($urandom), c);
               if (busy) o.busy_cycles++;
            end
         end
      end
      o.done = wr_done; o.err = frame_err; o.busy = busy;
      o.done3 = wr_done3; o.err3 = frame_err3;
      o.waddr = wr_addr; o.waddr3 = wr_addr3;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      obs_t o;
      int   a;
      logic [W-1:0] w;
      logic [13:0]  bits;

      model_reset();
      tbl[0] = '{2, 12'hE00, 1'b0, 1'b0, 1, 0, 1, 0, 2'd2, 2'd2, 14};
      tbl[1] = '{2, 12'hE00, 1'b1, 1'b0, 1, 0, 1, 0, 2'd2, 2'd2, 27};
      tbl[2] = '{3, 12'h7FF, 1'b0, 1'b1, 1, 0, 0, 1, 2'd3, 2'd2, 14};
      tbl[3] = '{0, 12'h800, 1'b0, 1'b0, 1, 0, 1, 0, 2'd0, 2'd0, 14};
      tbl[4] = '{1, to_q(0.75), 1'b1, 1'b0, 1, 0, 1, 0, 2'd1, 2'd1, 27};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_wr_done", 64'(wr_done), 64'(0));
      check("rst_frame_err", 64'(frame_err), 64'(0));
      check("rst_wr_addr", 64'(wr_addr), 64'(0));
      check_soglia("rst");
      rst = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_enable_ignored_busy", 64'(busy), 64'(0));

      // Table-driven frames.
      for (int t = 0; t < 5; t++) begin
         frame(tbl[t].addr, tbl[t].word, 0, tbl[t].toggle, tbl[t].commit_last, 1'b1, -1, o);
         check($sformatf("t%0d_wr_done", t), 64'(o.done), 64'(tbl[t].exp_done));
         check($sformatf("t%0d_frame_err", t), 64'(o.err), 64'(tbl[t].exp_err));
         check($sformatf("t%0d_wr_addr", t), 64'(o.waddr), 64'(tbl[t].exp_waddr));
         check($sformatf("t%0d_wr_done3", t), 64'(o.done3), 64'(tbl[t].exp_done3));
         check($sformatf("t%0d_frame_err3", t), 64'(o.err3), 64'(tbl[t].exp_err3));
         check($sformatf("t%0d_wr_addr3", t), 64'(o.waddr3), 64'(tbl[t].exp_waddr3));
         check($sformatf("t%0d_busy_after", t), 64'(o.busy), 64'(0));
         check($sformatf("t%0d_busy_cycles", t), 64'(o.busy_cycles), 64'(tbl[t].exp_busy));
         if (tbl[t].commit_last)
            check($sformatf("t%0d_bypass", t), 64'($unsigned(soglia[tbl[t].addr])), 64'(tbl[t].word));
         check_soglia($sformatf("t%0d_pre", t));
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         check($sformatf("t%0d_wr_done_pulse", t), 64'(wr_done), 64'(0));
         check($sformatf("t%0d_committed", t), 64'($unsigned(soglia[tbl[t].addr])), 64'(tbl[t].word));
         check_soglia($sformatf("t%0d_post", t));
      end

      // Abort after 5 data bits, then a complete frame without a new start.
      frame(3, 12'hABC, 0, 1'b0, 1'b0, 1'b1, 7, o);
      check("abort_frame_err", 64'(o.err), 64'(1));
      check("abort_no_wr_done", 64'(o.done), 64'(0));
      check("abort_busy", 64'(o.busy), 64'(1));
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_err_pulse", 64'(frame_err), 64'(0));
      frame(1, 12'h400, 0, 1'b0, 1'b0, 1'b0, -1, o);
      check("abort_next_done", 64'(o.done), 64'(1));
      check("abort_next_err", 64'(o.err), 64'(0));
      check("abort_next_addr", 64'(o.waddr), 64'(1));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("abort_soglia1", 64'($unsigned(soglia[1])), 64'(12'h400));
      check_soglia("abort");

      // Start coinciding with the last data bit discards the word.
      frame(0, 12'h123, 0, 1'b0, 1'b0, 1'b1, 13, o);
      check("lastbit_abort_err", 64'(o.err), 64'(1));
      check("lastbit_abort_done", 64'(o.done), 64'(0));
      frame(0, 12'h5A5, 0, 1'b0, 1'b0, 1'b0, -1, o);
      check("lastbit_next_done", 64'(o.done), 64'(1));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check_soglia("lastbit");

      // Start with enable high: that din is not the address MSB.
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      check("start_en_no_err", 64'(frame_err), 64'(0));
      frame(0, 12'h0AA, 1, 1'b0, 1'b0, 1'b0, -1, o);
      check("start_en_addr", 64'(o.waddr), 64'(0));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check_soglia("start_en");

      // Asynchronous reset in the middle of the data field.
      bits = {2'd2, 12'h111};
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, bits[13-i], 1'b0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("async_rst_busy", 64'(busy), 64'(0));
      check("async_rst_wr_addr", 64'(wr_addr), 64'(0));
      check_soglia("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      frame(2, 12'h0F0, 0, 1'b0, 1'b0, 1'b1, -1, o);
      check("post_rst_done", 64'(o.done), 64'(1));
      check("post_rst_addr", 64'(o.waddr), 64'(2));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check_soglia("post_rst");

      // Randomized frames against the model.
      for (int r = 0; r < 40; r++) begin
         a = int'($urandom_range(3, 0));
         w = W'($urandom);
         if ($urandom % 6 == 0) begin
            frame(int'($urandom_range(3, 0)), W'($urandom), 1, 1'b0, 1'b0, 1'b1,
                  int'($urandom_range(13, 0)), o);
            check($sformatf("r%0d_abort_err", r), 64'(o.err), 64'(1));
            frame(a, w, int'($urandom_range(2, 0)), 1'b0, ($urandom % 3 == 0), 1'b0, -1, o);
         end else begin
            frame(a, w, int'($urandom_range(2, 0)), 1'b0, ($urandom % 3 == 0), 1'b1, -1, o);
         end
         check($sformatf("r%0d_done", r), 64'(o.done), 64'(1));
         check($sformatf("r%0d_err", r), 64'(o.err), 64'(0));
         check($sformatf("r%0d_addr", r), 64'(o.waddr), 64'(a));
         check($sformatf("r%0d_done3", r), 64'(o.done3), 64'(a < N3));
         check($sformatf("r%0d_err3", r), 64'(o.err3), 64'(a >= N3));
         check($sformatf("r%0d_busy", r), 64'(o.busy), 64'(0));
         check_soglia($sformatf("r%0d", r));
         if ($urandom % 2 == 0) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check_soglia($sformatf("r%0d_c", r));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
